// File: rtl/wb_pipe_pkg.sv
// Shared definitions for the execute-to-writeback pipeline register.
// Covers the stage flag fields, the hard-wired zero register and the legal pipeline depth range.
package wb_pipe_pkg;

  localparam int unsigned ZERO_REG  = 0;
  localparam int unsigned MAX_DEPTH = 4;

  // Data and write-select widths are parameters of the top module, so only
  // the fixed-width control part of a stage entry can live here.
  typedef struct packed {
    logic valid;
    logic we;
  } stage_flags_t;

  function automatic bit depth_ok(input int depth);
    return (depth >= 1) && (depth <= int'(MAX_DEPTH));
  endfunction

endpackage

// File: rtl/wb_pipe_stage_fwd.sv
// Forwarding lookup for one read port: finds the youngest valid stage that
// writes the selected register and returns that stage's data.
module fwd_match
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1
) (
  input  logic [ADDR_W-1:0]       rd_sel,
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH-1:0]        we,
  input  logic [DEPTH*ADDR_W-1:0] ws,
  input  logic [DEPTH*DATA_W-1:0] data,
  output logic                    hit,
  output logic [DATA_W-1:0]       hit_data
);

  // Walk from oldest to youngest so that the youngest match is written last.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid[k] && we[k] &&
          (ws[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)) &&
          (ws[k*ADDR_W +: ADDR_W] == rd_sel)) begin
        hit      = 1'b1;
        hit_data = data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// Execute-to-writeback pipeline register. It supports configurable depth, stall and flush,
// suppresses writes to register 0, provides forwarding lookup ports and counts retired entries.
module wb_pipe_stage
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 1,
  parameter int NUM_RD   = 2,
  parameter int RETIRE_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [ADDR_W-1:0]        in_ws,
  input  logic                     in_we,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_ws,
  output logic                     out_we,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic [RETIRE_W-1:0]      retire_cnt
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("wb_pipe_stage: DEPTH must be between 1 and 4");
  end

  typedef struct packed {
    stage_flags_t        flags;
    logic [DATA_W-1:0]   data;
    logic [ADDR_W-1:0]   ws;
  } entry_t;

  entry_t stages [DEPTH];
  logic   out_commit;

  // Flush only clears valid bits, leaving the payload fields as don't-care.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stages[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stages[k].flags.valid <= 1'b0;
      end
    end else if (!stall) begin
      stages[0].flags.valid <= in_valid;
      stages[0].flags.we    <= in_we;
      stages[0].data        <= in_data;
      stages[0].ws          <= in_ws;
      for (int k = 1; k < DEPTH; k++) begin
        stages[k] <= stages[k-1];
      end
    end
  end

  assign out_valid  = stages[DEPTH-1].flags.valid;
  assign out_data   = stages[DEPTH-1].data;
  assign out_ws     = stages[DEPTH-1].ws;
  assign out_commit = out_valid & (~stall | flush);
  assign out_we     = out_commit & stages[DEPTH-1].flags.we &
                      (stages[DEPTH-1].ws != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
    end else if (out_commit) begin
      retire_cnt <= retire_cnt + RETIRE_W'(1);
    end
  end

  logic [DEPTH-1:0]        st_valid;
  logic [DEPTH-1:0]        st_we;
  logic [DEPTH*ADDR_W-1:0] st_ws;
  logic [DEPTH*DATA_W-1:0] st_data;

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign st_valid[k]                = stages[k].flags.valid;
    assign st_we[k]                   = stages[k].flags.we;
    assign st_ws[k*ADDR_W +: ADDR_W]  = stages[k].ws;
    assign st_data[k*DATA_W +: DATA_W] = stages[k].data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_fwd
    fwd_match #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_fwd (
      .rd_sel   (rd_sel[i*ADDR_W +: ADDR_W]),
      .valid    (st_valid),
      .we       (st_we),
      .ws       (st_ws),
      .data     (st_data),
      .hit      (fwd_hit[i]),
      .hit_data (fwd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench for wb_pipe_stage: a DEPTH=2 instance driven from a vector table,
// and a DEPTH=3 instance with a 2-bit retire counter for forwarding priority and wrap.
module tb_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_we, stall, flush;
  logic [31:0] in_data;
  logic [4:0]  in_ws;
  logic [9:0]  rd_sel;
  logic        out_valid, out_we;
  logic [31:0] out_data;
  logic [4:0]  out_ws;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic [31:0] retire_cnt;

  logic        d3_valid, d3_we;
  logic [31:0] d3_data;
  logic [4:0]  d3_ws;
  logic [9:0]  d3_rd_sel;
  logic        d3_out_valid, d3_out_we;
  logic [31:0] d3_out_data;
  logic [4:0]  d3_out_ws;
  logic [1:0]  d3_fwd_hit;
  logic [63:0] d3_fwd_data;
  logic [1:0]  d3_retire_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .NUM_RD(2), .RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ws(in_ws),
    .in_we(in_we), .stall(stall), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_ws(out_ws), .out_we(out_we), .rd_sel(rd_sel),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
  );

  wb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(3), .NUM_RD(2), .RETIRE_W(2)) dut3 (
    .clk(clk), .reset(reset), .in_valid(d3_valid), .in_data(d3_data), .in_ws(d3_ws),
    .in_we(d3_we), .stall(1'b0), .flush(1'b0), .out_valid(d3_out_valid),
    .out_data(d3_out_data), .out_ws(d3_out_ws), .out_we(d3_out_we), .rd_sel(d3_rd_sel),
    .fwd_hit(d3_fwd_hit), .fwd_data(d3_fwd_data), .retire_cnt(d3_retire_cnt)
  );

  typedef struct {
    logic        rst, v, we, st, fl;
    logic [31:0] d;
    logic [4:0]  ws, rd0, rd1;
    logic        eov, eowe, cmpd;
    logic [31:0] eod;
    logic [4:0]  eows;
    logic [1:0]  ehit;
    logic [31:0] efd0, efd1, erc;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic rst, v, input logic [31:0] d, input logic [4:0] ws, input logic we,
    input logic st, fl, input logic [4:0] rd0, rd1,
    input logic eov, input logic [31:0] eod, input logic [4:0] eows, input logic eowe,
    input logic cmpd, input logic [1:0] ehit, input logic [31:0] efd0, efd1, erc);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.ws = ws; r.we = we; r.st = st; r.fl = fl;
    r.rd0 = rd0; r.rd1 = rd1; r.eov = eov; r.eod = eod; r.eows = eows; r.eowe = eowe;
    r.cmpd = cmpd; r.ehit = ehit; r.efd0 = efd0; r.efd1 = efd1; r.erc = erc;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t t);
    @(negedge clk);
    reset = t.rst; in_valid = t.v; in_data = t.d; in_ws = t.ws; in_we = t.we;
    stall = t.st; flush = t.fl; rd_sel = {t.rd1, t.rd0};
    #1;
    checkOutput($sformatf("row%0d out_valid", idx), 32'(out_valid), 32'(t.eov));
    checkOutput($sformatf("row%0d out_we", idx), 32'(out_we), 32'(t.eowe));
    if (t.cmpd) begin
      checkOutput($sformatf("row%0d out_data", idx), out_data, t.eod);
      checkOutput($sformatf("row%0d out_ws", idx), 32'(out_ws), 32'(t.eows));
    end
    checkOutput($sformatf("row%0d fwd_hit", idx), 32'(fwd_hit), 32'(t.ehit));
    checkOutput($sformatf("row%0d fwd_data0", idx), fwd_data[31:0], t.efd0);
    checkOutput($sformatf("row%0d fwd_data1", idx), fwd_data[63:32], t.efd1);
    checkOutput($sformatf("row%0d retire_cnt", idx), retire_cnt, t.erc);
  endtask

  task automatic d3Step(input int idx, input logic v, input logic [31:0] d,
                        input logic [4:0] ws, input logic we,
                        input logic eov, input logic [31:0] eod, input logic eowe,
                        input logic [1:0] erc);
    @(negedge clk);
    d3_valid = v; d3_data = d; d3_ws = ws; d3_we = we;
    #1;
    checkOutput($sformatf("d3 step%0d out_valid", idx), 32'(d3_out_valid), 32'(eov));
    if (eov) checkOutput($sformatf("d3 step%0d out_data", idx), d3_out_data, eod);
    checkOutput($sformatf("d3 step%0d out_we", idx), 32'(d3_out_we), 32'(eowe));
    checkOutput($sformatf("d3 step%0d retire_cnt", idx), 32'(d3_retire_cnt), 32'(erc));
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_data = 0; in_ws = 0; in_we = 0;
    stall = 0; flush = 0; rd_sel = '0;
    d3_valid = 0; d3_data = 0; d3_ws = 0; d3_we = 0; d3_rd_sel = '0;

    //             rst v  data          ws we st fl rd0 rd1  ov od           ows owe cmp hit  fd0    fd1    rc
    vecs[0]  = mk(1, 1, 32'hDEADBEEF, 3, 1, 0, 0, 3, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 0);
    vecs[1]  = mk(1, 1, 32'hDEADBEEF, 3, 1, 0, 0, 3, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 0);
    vecs[2]  = mk(1, 1, 32'hDEADBEEF, 3, 1, 0, 0, 3, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 0);
    vecs[3]  = mk(0, 1, 32'h11,       4, 1, 0, 0, 4, 5,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 0);
    vecs[4]  = mk(0, 1, 32'h22,       5, 1, 0, 0, 4, 5,   0, 32'h0,      0, 0, 1, 2'b01, 32'h11, 32'h0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 4, 5,   1, 32'h11,     4, 1, 1, 2'b11, 32'h11, 32'h22, 0);
    vecs[6]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 5, 0,   1, 32'h22,     5, 1, 1, 2'b01, 32'h22, 32'h0, 1);
    vecs[7]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 4, 5,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 2);
    vecs[8]  = mk(0, 1, 32'h11,       4, 1, 0, 0, 4, 6,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 2);
    vecs[9]  = mk(0, 1, 32'h33,       6, 1, 0, 0, 4, 6,   0, 32'h0,      0, 0, 1, 2'b01, 32'h11, 32'h0, 2);
    vecs[10] = mk(0, 1, 32'h44,       7, 1, 1, 0, 4, 6,   1, 32'h11,     4, 0, 1, 2'b11, 32'h11, 32'h33, 2);
    vecs[11] = mk(0, 1, 32'h44,       7, 1, 1, 0, 4, 6,   1, 32'h11,     4, 0, 1, 2'b11, 32'h11, 32'h33, 2);
    vecs[12] = mk(0, 1, 32'h44,       7, 1, 1, 0, 4, 6,   1, 32'h11,     4, 0, 1, 2'b11, 32'h11, 32'h33, 2);
    vecs[13] = mk(0, 1, 32'h66,       8, 1, 0, 0, 4, 6,   1, 32'h11,     4, 1, 1, 2'b11, 32'h11, 32'h33, 2);
    vecs[14] = mk(0, 1, 32'h77,       9, 1, 1, 1, 8, 6,   1, 32'h33,     6, 1, 1, 2'b11, 32'h66, 32'h33, 3);
    vecs[15] = mk(0, 0, 32'h0,        0, 0, 0, 0, 8, 6,   0, 32'h0,      0, 0, 0, 2'b00, 32'h0, 32'h0, 4);
    vecs[16] = mk(0, 1, 32'h55,       0, 1, 0, 0, 0, 0,   0, 32'h0,      0, 0, 0, 2'b00, 32'h0, 32'h0, 4);
    vecs[17] = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 4);
    vecs[18] = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 0,   1, 32'h55,     0, 0, 1, 2'b00, 32'h0, 32'h0, 4);
    vecs[19] = mk(0, 0, 32'h0,        0, 0, 0, 0, 0, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 5);
    vecs[20] = mk(0, 0, 32'h99,       3, 1, 0, 0, 3, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 5);
    vecs[21] = mk(0, 0, 32'h0,        0, 0, 0, 0, 3, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 5);
    vecs[22] = mk(0, 0, 32'h0,        0, 0, 0, 0, 3, 0,   0, 32'h99,     3, 0, 1, 2'b00, 32'h0, 32'h0, 5);
    vecs[23] = mk(0, 0, 32'h0,        0, 0, 0, 0, 3, 0,   0, 32'h0,      0, 0, 1, 2'b00, 32'h0, 32'h0, 5);

    repeat (2) @(posedge clk);
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // DEPTH=3 instance: three-cycle latency, youngest-wins forwarding, 2-bit counter wrap.
    @(negedge clk);
    reset = 1'b1; in_valid = 0; in_we = 0; stall = 0; flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    d3_rd_sel = {5'd9, 5'd7};
    d3Step(1, 1, 32'hBB, 7, 1,   0, 32'h0,  0, 2'd0);
    d3Step(2, 1, 32'hCC, 9, 0,   0, 32'h0,  0, 2'd0);
    d3Step(3, 1, 32'hAA, 7, 1,   0, 32'h0,  0, 2'd0);
    d3Step(4, 1, 32'hDD, 1, 1,   1, 32'hBB, 1, 2'd0);
    checkOutput("d3 fwd_hit priority", 32'(d3_fwd_hit), 32'b01);
    checkOutput("d3 fwd_data0 youngest", d3_fwd_data[31:0], 32'hAA);
    checkOutput("d3 fwd_data1 no-we", d3_fwd_data[63:32], 32'h0);
    d3Step(5, 0, 32'h0, 0, 0,    1, 32'hCC, 0, 2'd1);
    d3Step(6, 0, 32'h0, 0, 0,    1, 32'hAA, 1, 2'd2);
    d3Step(7, 0, 32'h0, 0, 0,    1, 32'hDD, 1, 2'd3);
    d3Step(8, 0, 32'h0, 0, 0,    0, 32'h0,  0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
- Parametrised execute-to-writeback pipeline register; successor to the fixed single-stage ALU-result/write-select/write-enable latch.
- Adds configurable depth, valid tracking, stall and flush control, register-0 write suppression, multi-port forwarding lookup and a retire counter.
- Sits between the ALU output and the register-file write port; forwarding outputs feed the operand-select muxes in decode/execute.

Parameters:
- DATA_W, 32, width of the ALU result carried.
- ADDR_W, 5, register write-select width.
- DEPTH, 1, number of register stages (legal 1..4); stage 0 is youngest, stage DEPTH-1 drives the outputs.
- NUM_RD, 2, number of forwarding lookup ports.
- RETIRE_W, 32, retire counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  incoming instruction valid.
- in_data  in  DATA_W  ALU result.
- in_ws  in  ADDR_W  destination register.
- in_we  in  1  register write request.
- stall  in  1  hold all stages.
- flush  in  1  invalidate all stages.
- out_valid  out  1  final stage holds a valid entry.
- out_data  out  DATA_W  final stage data.
- out_ws  out  ADDR_W  final stage write select.
- out_we  out  1  qualified register-file write strobe.
- rd_sel  in  NUM_RD*ADDR_W  packed read selects; port i occupies bits [i*ADDR_W +: ADDR_W].
- fwd_hit  out  NUM_RD  forwarding match per port.
- fwd_data  out  NUM_RD*DATA_W  forwarded data per port, packed the same way.
- retire_cnt  out  RETIRE_W  count of committed entries.

Behaviour:
- Clocking and reset: clock is clk; reset is reset, synchronous, active-high. On reset, all stage valid/data/ws/we fields and retire_cnt go to 0, so every output is 0 after the edge.
- Advance (stall=0, flush=0):
  - stage0 <= {in_valid, in_data, in_ws, in_we}.
  - stage k <= stage k-1.
  - Latency is exactly DEPTH cycles from input to out_*.
- Stall (stall=1, flush=0): all stages hold their contents; inputs are ignored. Upstream must hold its own state.
- Flush (flush=1): every stage valid bit <= 0 regardless of stall; flush has priority over stall. Data/ws/we fields may take don't-care values, but outputs gated by valid must be 0.
- Reset has priority over flush and stall. Reset mid-stream discards all in-flight entries.
- Commit and outputs:
  - out_commit = out_valid & (~stall | flush), combinational. The entry presented in the final stage commits once, on the edge where it leaves.
  - out_we = out_commit & stageN.we & (stageN.ws != 0). A write to register 0 never strobes but still counts as retired.
  - out_data and out_ws reflect the final stage unconditionally; their value matters only when out_valid=1.
- Retire counter: retire_cnt increments by 1 on each edge where out_commit=1. It wraps modulo 2^RETIRE_W and is not saturating.
- Forwarding (combinational, per port i):
  - A candidate is stage k with valid & we & (ws != 0) & (ws == rd_sel[i]).
  - The youngest match wins: lowest k has priority.
  - fwd_hit[i] = 1 if any stage is a candidate; fwd_data[i] = the winner's data, else 0.
  - rd_sel == 0 never hits. The in_* inputs are not searched.
  - Forwarding remains active during stall. It reflects the current register contents during a flush cycle; the flush takes effect at the next edge.
- DEPTH=1 with stall and flush tied low must match the legacy single-stage latch cycle-for-cycle on data/ws/we.

Decomposition:
- Shared package wb_pipe_pkg holds:
  - the stage-entry struct {valid, data, ws, we};
  - the constant ZERO_REG = 0;
  - the DEPTH legality check.
- Sub-module fwd_match, instantiated NUM_RD times: priority-compare one read select against all stage entries, returning hit and data.
- The stage shift array and retire counter stay in the top module.

Test Plan:
- Reset, DEPTH=2: drive in_valid=1, in_data=0xDEADBEEF, in_ws=3, in_we=1 with reset=1 for 3 cycles -> out_valid=0, out_we=0, out_data=0, retire_cnt=0 throughout.
- Streaming, DEPTH=2: inputs A=(0x11,ws 4), B=(0x22,ws 5) on consecutive cycles -> out_data=0x11/out_we=1 two cycles after A, then 0x22 one cycle later; retire_cnt=2.
- Stall: A held in the final stage, stall=1 for 3 cycles -> out_data holds 0x11, out_we=0 during the stall. On release, one out_we pulse and retire_cnt increments by exactly 1.
- Flush with stall asserted in the same cycle, 2 entries in flight -> next cycle out_valid=0, both stages invalid; the entry presented in the flush cycle commits (out_we=1 that cycle).
- Zero-register write: in_ws=0, in_we=1, data=0x55 -> out_we never asserts, retire_cnt increments, and rd_sel=0 gives fwd_hit=0.
- Forwarding priority, DEPTH=3: stage0 ws=7 data=0xAA, stage2 ws=7 data=0xBB, rd_sel port0=7, port1=9 -> fwd_hit=2'b01 (port0 hit), fwd_data port0=0xAA, port1=0.
